sram_arbiter: RTL and testbench

- Sequences every access to the shared 64Kx8 SRAM and arbitrates it between two requesters: the AVR/SPI side (port A) and the CoCo bus side (port C).
- Each requester uses a req/ack handshake. The block owns all SRAM control strobes and enforces a fixed access width (ACCESS_TICKS clocks) plus one recovery clock.
- Port A has priority. A starvation guard guarantees port C a grant.

---
 rtl/sram_arbiter_if.sv | 46 ++++
 rtl/sram_arbiter.sv | 117 +++++++++++
 tb/tb_sram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Signal bundle between the SRAM arbiter, its two requesters and the SRAM pads.
// slave = arbiter side, master = requesters plus the SRAM device.
interface sram_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [15:0] a_addr;
  logic [7:0]  a_wdata;
  logic        a_ack;
  logic [7:0]  a_rdata;

  logic        c_req;
  logic        c_we;
  logic [15:0] c_addr;
  logic [7:0]  c_wdata;
  logic        c_ack;
  logic [7:0]  c_rdata;

  logic [15:0] sram_addrbus;
  logic [7:0]  sram_dout;
  logic        sram_dout_en;
  logic [7:0]  sram_din;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;

  logic        busy;
  logic        owner;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  c_req, c_we, c_addr, c_wdata,
    input  sram_din,
    output a_ack, a_rdata, c_ack, c_rdata,
    output sram_addrbus, sram_dout, sram_dout_en, sram_we_n, sram_oe_n, sram_ce_n,
    output busy, owner
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output c_req, c_we, c_addr, c_wdata,
    output sram_din,
    input  a_ack, a_rdata, c_ack, c_rdata,
    input  sram_addrbus, sram_dout, sram_dout_en, sram_we_n, sram_oe_n, sram_ce_n,
    input  busy, owner
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a shared 64Kx8 asynchronous SRAM.
// Port A has priority; a starvation counter forces a port C grant.
module sram_arbiter #(
  parameter int ACCESS_TICKS = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock_50,
  input  logic          reset_n,
  sram_arbiter_if.slave bus
);

  localparam int TW = $clog2(ACCESS_TICKS);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TICK_LOAD  = TW'(ACCESS_TICKS - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  typedef struct packed {
    state_t        state;
    logic [TW-1:0] tick;
    logic [SW-1:0] starve;
    logic [15:0]   addr;
    logic [7:0]    dout;
    logic          dout_en;
    logic          we_n;
    logic          oe_n;
    logic          a_ack;
    logic          c_ack;
    logic [7:0]    a_rdata;
    logic [7:0]    c_rdata;
    logic          owner;
    logic          busy;
  } regs_t;

  localparam regs_t REGS_RESET = '{
    state: IDLE, tick: '0, starve: '0, addr: '0, dout: '0, dout_en: 1'b0,
    we_n: 1'b1, oe_n: 1'b1, a_ack: 1'b0, c_ack: 1'b0,
    a_rdata: '0, c_rdata: '0, owner: 1'b0, busy: 1'b0
  };

  regs_t r, r_n;
  logic  grant_c;
  logic  grant_we;

  always_comb begin
    // NOTE: every field gets a default before the case, so no path can infer a latch.
    r_n       = r;
    r_n.a_ack = 1'b0;
    r_n.c_ack = 1'b0;
    grant_c   = bus.c_req && (!bus.a_req || r.starve == STARVE_MAX);
    grant_we  = grant_c ? bus.c_we : bus.a_we;

    case (r.state)
      IDLE: begin
        if (bus.a_req || bus.c_req) begin
          r_n.state   = ACCESS;
          r_n.tick    = TICK_LOAD;
          r_n.owner   = !grant_c;
          r_n.addr    = grant_c ? bus.c_addr  : bus.a_addr;
          r_n.dout    = grant_c ? bus.c_wdata : bus.a_wdata;
          r_n.we_n    = !grant_we;
          r_n.oe_n    = grant_we;
          r_n.dout_en = grant_we;
          if (grant_c)
            r_n.starve = '0;
          else if (bus.c_req && r.starve != STARVE_MAX)
            r_n.starve = r.starve + 1'b1;
        end
      end

      ACCESS: begin
        if (r.tick != '0) begin
          r_n.tick = r.tick - 1'b1;
        end else begin
          // dout_en doubles as the write flag of the access in flight
          if (!r.dout_en) begin
            if (r.owner) r_n.a_rdata = bus.sram_din;
            else         r_n.c_rdata = bus.sram_din;
          end
          r_n.a_ack   = r.owner;
          r_n.c_ack   = !r.owner;
          r_n.we_n    = 1'b1;
          r_n.oe_n    = 1'b1;
          r_n.dout_en = 1'b0;
          r_n.state   = RECOVER;
        end
      end

      RECOVER: r_n.state = IDLE;

      default: r_n.state = IDLE;
    endcase

    r_n.busy = (r_n.state != IDLE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) r <= REGS_RESET;
    else          r <= r_n;
  end

  assign bus.a_ack        = r.a_ack;
  assign bus.a_rdata      = r.a_rdata;
  assign bus.c_ack        = r.c_ack;
  assign bus.c_rdata      = r.c_rdata;
  assign bus.sram_addrbus = r.addr;
  assign bus.sram_dout    = r.dout;
  assign bus.sram_dout_en = r.dout_en;
  assign bus.sram_we_n    = r.we_n;
  assign bus.sram_oe_n    = r.oe_n;
  assign bus.sram_ce_n    = 1'b0;
  assign bus.busy         = r.busy;
  assign bus.owner        = r.owner;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: SRAM behavioural model, one task per scenario.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_sram_arbiter;

  logic clock_50 = 1'b0;
  logic reset_n  = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  always #10 clock_50 = ~clock_50;

  sram_arbiter_if bus  ();
  sram_arbiter_if bus5 ();

  sram_arbiter #(.ACCESS_TICKS(3), .STARVE_LIMIT(4)) dut (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  sram_arbiter #(.ACCESS_TICKS(5), .STARVE_LIMIT(4)) dut5 (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .bus      (bus5)
  );

  logic [7:0] mem [0:65535];
  assign bus.sram_din  = mem[bus.sram_addrbus];
  assign bus5.sram_din = 8'hA7;

  always @(posedge clock_50)
    if (!bus.sram_we_n && bus.sram_dout_en) mem[bus.sram_addrbus] <= bus.sram_dout;

  typedef struct {
    int         we_low;
    int         oe_low;
    int         den_high;
    int         busy_high;
    int         acks;
    int         grants;
    int         ack_at;
    logic [7:0] rdata;
    logic       owner;
  } meas_t;

  task automatic apply_reset;
    @(negedge clock_50) reset_n = 1'b0;
    @(negedge clock_50) reset_n = 1'b1;
  endtask

  // Issue one request on A or C and watch 25 clocks; req drops 'hold' clocks after ack.
  task automatic access(input bit port_a, input bit we, input logic [15:0] addr,
                        input logic [7:0] wdata, input int hold, output meas_t m);
    int   drop_at;
    logic prev_busy;
    logic ack;
    m = '{default: 0};
    m.ack_at = -1;
    drop_at  = -1;
    @(negedge clock_50);
    prev_busy = bus.busy;
    if (port_a) begin
      bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata; bus.a_req = 1'b1;
    end else begin
      bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_req = 1'b1;
    end
    for (int i = 1; i <= 25; i++) begin
      @(negedge clock_50);
      if (!bus.sram_we_n)         m.we_low++;
      if (!bus.sram_oe_n)         m.oe_low++;
      if (bus.sram_dout_en)       m.den_high++;
      if (bus.busy)               m.busy_high++;
      if (bus.busy && !prev_busy) m.grants++;
      prev_busy = bus.busy;
      ack = port_a ? bus.a_ack : bus.c_ack;
      if (ack) begin
        m.acks++;
        if (m.ack_at < 0) begin
          m.ack_at = i - 1;
          m.owner  = bus.owner;
          drop_at  = i + hold;
        end
      end
      if (i == drop_at) begin
        if (port_a) bus.a_req = 1'b0;
        else        bus.c_req = 1'b0;
      end
    end
    bus.a_req = 1'b0;
    bus.c_req = 1'b0;
    m.rdata = port_a ? bus.a_rdata : bus.c_rdata;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock_50);
    checks++;
    if ({bus.a_ack, bus.c_ack, bus.sram_we_n, bus.sram_oe_n, bus.sram_dout_en,
         bus.busy, bus.owner, bus.sram_ce_n} !== 8'b0011_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00110000 (a_ack c_ack we_n oe_n dout_en busy owner ce_n)",
               {bus.a_ack, bus.c_ack, bus.sram_we_n, bus.sram_oe_n, bus.sram_dout_en,
                bus.busy, bus.owner, bus.sram_ce_n});
    end
    checks++;
    if ({bus.sram_addrbus, bus.sram_dout, bus.a_rdata, bus.c_rdata} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h dout=%h a_rdata=%h c_rdata=%h expected all zero",
               bus.sram_addrbus, bus.sram_dout, bus.a_rdata, bus.c_rdata);
    end
    @(negedge clock_50) reset_n = 1'b1;
  endtask

  task automatic test_single_a;
    meas_t m;
    access(1'b1, 1'b1, 16'h1234, 8'h5A, 0, m);
    checks++;
    if (m.we_low !== 3) begin errors++; $display("FAIL wr_we_width: got %0d expected 3", m.we_low); end
    checks++;
    if (m.den_high !== 3 || m.oe_low !== 0) begin
      errors++; $display("FAIL wr_den_oe: got den=%0d oe=%0d expected den=3 oe=0", m.den_high, m.oe_low);
    end
    checks++;
    if (m.acks !== 1 || m.ack_at !== 3) begin
      errors++; $display("FAIL wr_ack: got count=%0d at=%0d expected count=1 at=3", m.acks, m.ack_at);
    end
    checks++;
    if (m.busy_high !== 4 || m.owner !== 1'b1) begin
      errors++; $display("FAIL wr_busy_owner: got busy=%0d owner=%0d expected busy=4 owner=1", m.busy_high, m.owner);
    end
    checks++;
    if (bus.sram_addrbus !== 16'h1234) begin
      errors++; $display("FAIL addr_hold: got %h expected 1234", bus.sram_addrbus);
    end

    access(1'b1, 1'b0, 16'h1234, 8'h00, 0, m);
    checks++;
    if (m.rdata !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h expected 5a", m.rdata); end
    checks++;
    if (m.oe_low !== 3 || m.we_low !== 0 || m.den_high !== 0) begin
      errors++; $display("FAIL rd_strobes: got oe=%0d we=%0d den=%0d expected oe=3 we=0 den=0",
                         m.oe_low, m.we_low, m.den_high);
    end
    checks++;
    if (m.acks !== 1 || m.ack_at !== 3 || m.busy_high !== 4) begin
      errors++; $display("FAIL rd_ack_busy: got acks=%0d at=%0d busy=%0d expected 1 3 4", m.acks, m.ack_at, m.busy_high);
    end

    access(1'b1, 1'b1, 16'h1235, 8'h77, 0, m);
    checks++;
    if (m.rdata !== 8'h5A) begin errors++; $display("FAIL rdata_after_write: got %h expected 5a", m.rdata); end
  endtask

  task automatic test_same_clock;
    meas_t      m;
    logic [1:0] own;
    int         n, first_at, second_at, a_acks, c_acks;
    logic       prev_busy;
    access(1'b0, 1'b1, 16'h8000, 8'h3C, 0, m);
    checks++;
    if (m.acks !== 1 || m.owner !== 1'b0 || m.we_low !== 3) begin
      errors++; $display("FAIL c_write: got acks=%0d owner=%0d we=%0d expected 1 0 3", m.acks, m.owner, m.we_low);
    end

    @(negedge clock_50);
    bus.a_we = 1'b0; bus.a_addr = 16'h1234;
    bus.c_we = 1'b0; bus.c_addr = 16'h8000;
    bus.a_req = 1'b1; bus.c_req = 1'b1;
    prev_busy = bus.busy;
    own = '0; n = 0; first_at = 0; second_at = 0; a_acks = 0; c_acks = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock_50);
      if (bus.busy && !prev_busy) begin
        own = {own[0], bus.owner};
        n++;
        if (n == 1) first_at = i;
        if (n == 2) second_at = i;
      end
      prev_busy = bus.busy;
      if (bus.a_ack) begin a_acks++; bus.a_req = 1'b0; end
      if (bus.c_ack) begin c_acks++; bus.c_req = 1'b0; end
    end
    bus.a_req = 1'b0; bus.c_req = 1'b0;
    checks++;
    if (n !== 2 || own !== 2'b10) begin
      errors++; $display("FAIL both_order: got grants=%0d owners=%b expected 2 10", n, own);
    end
    checks++;
    if (second_at - first_at !== 5) begin
      errors++; $display("FAIL b2b_spacing: got %0d expected 5", second_at - first_at);
    end
    checks++;
    if (a_acks !== 1 || c_acks !== 1) begin
      errors++; $display("FAIL both_acks: got a=%0d c=%0d expected 1 1", a_acks, c_acks);
    end
    checks++;
    if (bus.a_rdata !== 8'h5A || bus.c_rdata !== 8'h3C) begin
      errors++; $display("FAIL both_rdata: got a=%h c=%h expected 5a 3c", bus.a_rdata, bus.c_rdata);
    end
  endtask

  task automatic test_hold;
    meas_t m;
    access(1'b1, 1'b0, 16'h1234, 8'h00, 1, m);
    checks++;
    if (m.grants !== 1 || m.acks !== 1) begin
      errors++; $display("FAIL hold_one: got grants=%0d acks=%0d expected 1 1", m.grants, m.acks);
    end
    access(1'b1, 1'b0, 16'h1234, 8'h00, 2, m);
    checks++;
    if (m.grants !== 2 || m.acks !== 2 || m.rdata !== 8'h5A) begin
      errors++; $display("FAIL hold_extra: got grants=%0d acks=%0d rdata=%h expected 2 2 5a",
                         m.grants, m.acks, m.rdata);
    end
  endtask

  task automatic test_starvation;
    logic [11:0] seq;
    int          n;
    logic        prev_busy;
    apply_reset();
    @(negedge clock_50);
    bus.a_we = 1'b0; bus.a_addr = 16'h0010;
    bus.c_we = 1'b0; bus.c_addr = 16'h8000;
    bus.a_req = 1'b1; bus.c_req = 1'b1;
    prev_busy = bus.busy;
    seq = '0; n = 0;
    for (int i = 1; i <= 100 && n < 12; i++) begin
      @(negedge clock_50);
      if (bus.busy && !prev_busy) begin
        seq = {seq[10:0], bus.owner};
        n++;
        if (n == 7) bus.c_req = 1'b1;
      end
      prev_busy = bus.busy;
      if (bus.c_ack) bus.c_req = 1'b0;
    end
    bus.a_req = 1'b0; bus.c_req = 1'b0;
    repeat (8) @(negedge clock_50);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL starve_grants: got %0d expected 12", n); end
    checks++;
    if (seq !== 12'b1111_0111_1110) begin
      errors++; $display("FAIL starve_seq: got %b expected 111101111110", seq);
    end
    checks++;
    if (bus.c_rdata !== 8'h3C) begin errors++; $display("FAIL starve_c_rdata: got %h expected 3c", bus.c_rdata); end
  endtask

  task automatic test_reset_mid_access;
    meas_t m;
    int    acks;
    logic  busy_seen;
    @(negedge clock_50);
    bus.a_we = 1'b1; bus.a_addr = 16'h2000; bus.a_wdata = 8'hEE; bus.a_req = 1'b1;
    repeat (2) @(negedge clock_50);
    checks++;
    if (bus.sram_we_n !== 1'b0) begin errors++; $display("FAIL mid_we_active: got %b expected 0", bus.sram_we_n); end
    reset_n = 1'b0;
    bus.a_req = 1'b0;
    #1;
    checks++;
    if ({bus.sram_we_n, bus.sram_dout_en, bus.busy, bus.a_ack} !== 4'b1000) begin
      errors++; $display("FAIL mid_reset_strobes: got %b expected 1000 (we_n dout_en busy a_ack)",
                         {bus.sram_we_n, bus.sram_dout_en, bus.busy, bus.a_ack});
    end
    checks++;
    if (bus.sram_addrbus !== 16'h0000) begin errors++; $display("FAIL mid_reset_addr: got %h expected 0000", bus.sram_addrbus); end
    @(negedge clock_50) reset_n = 1'b1;
    acks = 0; busy_seen = 1'b0;
    repeat (8) begin
      @(negedge clock_50);
      if (bus.a_ack) acks++;
      if (bus.busy) busy_seen = 1'b1;
    end
    checks++;
    if (acks !== 0 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL mid_no_ack: got acks=%0d busy=%0d expected 0 0", acks, busy_seen);
    end
    access(1'b1, 1'b0, 16'h1234, 8'h00, 0, m);
    checks++;
    if (m.acks !== 1 || m.ack_at !== 3 || m.rdata !== 8'h5A) begin
      errors++; $display("FAIL mid_fresh: got acks=%0d at=%0d rdata=%h expected 1 3 5a", m.acks, m.ack_at, m.rdata);
    end
  endtask

  task automatic access5(input bit we, output int we_low, output int oe_low,
                         output int busy_high, output int ack_at);
    we_low = 0; oe_low = 0; busy_high = 0; ack_at = -1;
    @(negedge clock_50);
    bus5.a_we = we; bus5.a_addr = 16'h0042; bus5.a_wdata = 8'h99; bus5.a_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock_50);
      if (!bus5.sram_we_n) we_low++;
      if (!bus5.sram_oe_n) oe_low++;
      if (bus5.busy)       busy_high++;
      if (bus5.a_ack && ack_at < 0) begin ack_at = i - 1; bus5.a_req = 1'b0; end
    end
    bus5.a_req = 1'b0;
  endtask

  task automatic test_ticks5;
    int we_low, oe_low, busy_high, ack_at;
    access5(1'b1, we_low, oe_low, busy_high, ack_at);
    checks++;
    if (we_low !== 5 || ack_at !== 5 || busy_high !== 6) begin
      errors++; $display("FAIL t5_write: got we=%0d ack_at=%0d busy=%0d expected 5 5 6", we_low, ack_at, busy_high);
    end
    access5(1'b0, we_low, oe_low, busy_high, ack_at);
    checks++;
    if (oe_low !== 5 || ack_at !== 5 || bus5.a_rdata !== 8'hA7) begin
      errors++; $display("FAIL t5_read: got oe=%0d ack_at=%0d rdata=%h expected 5 5 a7", oe_low, ack_at, bus5.a_rdata);
    end
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus5.a_req = 1'b0; bus5.a_we = 1'b0; bus5.a_addr = '0; bus5.a_wdata = '0;
    bus5.c_req = 1'b0; bus5.c_we = 1'b0; bus5.c_addr = '0; bus5.c_wdata = '0;

    test_reset();
    test_single_a();
    test_same_clock();
    test_hold();
    test_starvation();
    test_reset_mid_access();
    test_ticks5();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
